// File: rtl/nonce_dispatcher.sv
// rtl/nonce_dispatcher.sv - issues a contiguous nonce range for one mining job over valid/ready
//
// nonce_counter: WIDTH-bit up-counter with synchronous reset to INITIALCOUNT.
//   clk, rst    : clock, synchronous active-high reset (also used to clear per job)
//   inc         : add INCREMENT on the next rising edge
//   count       : registered count value
//
// nonce_dispatcher: loads a job (base, len) in IDLE and offers base + count
// to the hash core one nonce per accepted transfer until len nonces are
// consumed or the job is aborted.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : load a new job (IDLE only), samples base_i / len_i
//   base_i, len_i     : first nonce and number of nonces of the job
//   abort_i           : terminate the running job (RUN only)
//   nonce_o           : base + count, modulo 2^WIDTH
//   nonce_valid_o     : nonce_o is offered (state is RUN)
//   nonce_ready_i     : downstream accepts nonce_o this cycle
//   busy_o            : state is not IDLE
//   done_o            : one-cycle pulse when a job ends
//   aborted_o         : qualifies done_o, held until the next accepted start
//   issued_o          : nonces transferred in the current or last job

module nonce_counter #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   INITIALCOUNT = '0,
  parameter logic [WIDTH-1:0]   INCREMENT    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + INCREMENT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= INITIALCOUNT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

module nonce_dispatcher #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] len_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] nonce_o,
  output logic             nonce_valid_o,
  input  logic             nonce_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [WIDTH-1:0] issued_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] base_d;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] len_d;
  logic             done_q;
  logic             done_d;
  logic             aborted_q;
  logic             aborted_d;

  logic [WIDTH-1:0] count;
  logic             cnt_rst;
  logic             cnt_inc;
  logic             xfer;
  logic             last_xfer;
  logic             start_acc;

  // Transfers only happen while offering, so the counter can never run past len.
  assign xfer      = (state_q == RUN) && nonce_ready_i;
  // len is nonzero whenever we are in RUN, so len - 1 never underflows here.
  assign last_xfer = xfer && (count == (len_q - WIDTH'(1)));
  assign start_acc = (state_q == IDLE) && start_i;

  // Clearing the counter on an accepted start makes issued_o hold the last
  // job's total right up until the next job is loaded.
  assign cnt_rst = rst || start_acc;
  assign cnt_inc = xfer;

  nonce_counter #(
    .WIDTH        (WIDTH),
    .INITIALCOUNT ('0),
    .INCREMENT    (WIDTH'(1))
  ) u_counter (
    .clk   (clk),
    .rst   (cnt_rst),
    .inc   (cnt_inc),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d    = base_i;
          len_d     = len_i;
          aborted_d = 1'b0;
          if (len_i == '0) begin
            // Empty job: report completion without ever offering a nonce.
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A final transfer wins over a simultaneous abort: the job completed.
        if (last_xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (abort_i) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // All outputs come from registers only; nonce_ready_i never reaches them combinationally.
  assign nonce_o       = base_q + count;
  assign nonce_valid_o = (state_q == RUN);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign issued_o      = count;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb/tb_nonce_dispatcher.sv - directed table-driven bench for nonce_dispatcher

module tb_nonce_dispatcher;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] base_i;
  logic [31:0] len_i;
  logic        abort_i;
  logic [31:0] nonce_o;
  logic        nonce_valid_o;
  logic        nonce_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        aborted_o;
  logic [31:0] issued_o;

  int checks = 0;
  int errors = 0;

  nonce_dispatcher #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_i        (base_i),
    .len_i         (len_i),
    .abort_i       (abort_i),
    .nonce_o       (nonce_o),
    .nonce_valid_o (nonce_valid_o),
    .nonce_ready_i (nonce_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .aborted_o     (aborted_o),
    .issued_o      (issued_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [31:0] len;
    logic        abort;
    logic        ready;
    logic [31:0] e_nonce;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic        e_aborted;
    logic [31:0] e_issued;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [31:0] b, input logic [31:0] l,
                     input logic a, input logic rd, input logic [31:0] en, input logic ev,
                     input logic eb, input logic ed, input logic ea, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.start = s; v.base = b; v.len = l; v.abort = a; v.ready = rd;
    v.e_nonce = en; v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_aborted = ea; v.e_issued = ei;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] en, input logic ev, input logic eb,
                       input logic ed, input logic ea, input logic [31:0] ei);
    checks++;
    if (nonce_o !== en || nonce_valid_o !== ev || busy_o !== eb ||
        done_o !== ed || aborted_o !== ea || issued_o !== ei) begin
      errors++;
      $display("FAIL %s: got nonce=%h valid=%b busy=%b done=%b aborted=%b issued=%0d, expected nonce=%h valid=%b busy=%b done=%b aborted=%b issued=%0d",
               name, nonce_o, nonce_valid_o, busy_o, done_o, aborted_o, issued_o,
               en, ev, eb, ed, ea, ei);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs driven for one cycle; expected outputs seen just after that edge.
    //   rst start base          len  abort ready | nonce         v  b  d  a  issued
    add(1, 0, 32'h0,        32'd0, 0, 0,   32'h0,        0, 0, 0, 0, 0);  // reset
    add(0, 0, 32'h0,        32'd0, 0, 0,   32'h0,        0, 0, 0, 0, 0);
    // basic job, ready held high
    add(0, 1, 32'h100,      32'd4, 0, 1,   32'h100,      1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h101,      1, 1, 0, 0, 1);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h102,      1, 1, 0, 0, 2);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h103,      1, 1, 0, 0, 3);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h104,      0, 0, 1, 0, 4);
    add(0, 0, 32'h0,        32'd0, 0, 0,   32'h104,      0, 0, 0, 0, 4);
    // backpressure, ready pattern 1,0,0,1,1,0,1
    add(0, 1, 32'h100,      32'd4, 0, 0,   32'h100,      1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h101,      1, 1, 0, 0, 1);
    add(0, 0, 32'h0,        32'd0, 0, 0,   32'h101,      1, 1, 0, 0, 1);
    add(0, 0, 32'h0,        32'd0, 0, 0,   32'h101,      1, 1, 0, 0, 1);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h102,      1, 1, 0, 0, 2);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h103,      1, 1, 0, 0, 3);
    add(0, 0, 32'h0,        32'd0, 0, 0,   32'h103,      1, 1, 0, 0, 3);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h104,      0, 0, 1, 0, 4);
    // start on the done cycle, wrapping job; start during RUN ignored
    add(0, 1, 32'hFFFFFFFE, 32'd3, 0, 1,   32'hFFFFFFFE, 1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'hFFFFFFFF, 1, 1, 0, 0, 1);
    add(0, 1, 32'h5,        32'd9, 0, 1,   32'h00000000, 1, 1, 0, 0, 2);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h00000001, 0, 0, 1, 0, 3);
    // len = 0
    add(0, 1, 32'h50,       32'd0, 0, 1,   32'h50,       0, 0, 1, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h50,       0, 0, 0, 0, 0);
    // abort together with the last transfer is a normal completion
    add(0, 1, 32'h7,        32'd2, 0, 1,   32'h7,        1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h8,        1, 1, 0, 0, 1);
    add(0, 0, 32'h0,        32'd0, 1, 1,   32'h9,        0, 0, 1, 0, 2);
    // abort without transfer; abort in IDLE ignored; aborted held then cleared by start
    add(0, 1, 32'h20,       32'd5, 0, 0,   32'h20,       1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 1, 0,   32'h20,       0, 0, 1, 1, 0);
    add(0, 0, 32'h0,        32'd0, 1, 0,   32'h20,       0, 0, 0, 1, 0);
    add(0, 1, 32'h30,       32'd3, 0, 0,   32'h30,       1, 1, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h31,       1, 1, 0, 0, 1);
    // reset mid-job
    add(1, 0, 32'h0,        32'd0, 0, 1,   32'h0,        0, 0, 0, 0, 0);
    add(0, 0, 32'h0,        32'd0, 0, 1,   32'h0,        0, 0, 0, 0, 0);

    rst = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0; abort_i = 1'b0; nonce_ready_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      start_i       = vecs[i].start;
      base_i        = vecs[i].base;
      len_i         = vecs[i].len;
      abort_i       = vecs[i].abort;
      nonce_ready_i = vecs[i].ready;
      step();
      check($sformatf("vec%0d", i), vecs[i].e_nonce, vecs[i].e_valid, vecs[i].e_busy,
            vecs[i].e_done, vecs[i].e_aborted, vecs[i].e_issued);
    end

    // Abort on the cycle nonce 5 transfers: that nonce counts.
    rst = 1'b0; start_i = 1'b1; base_i = 32'h0; len_i = 32'd100; abort_i = 1'b0; nonce_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    check("abort_first", 32'h0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
    end
    check("abort_at5", 32'h5, 1, 1, 0, 0, 5);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_done", 32'h6, 0, 0, 1, 1, 6);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("abort_after%0d", k), 32'h6, 0, 0, 0, 1, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
